rgb_fade_sequencer: RTL and testbench

Autonomous colour-sequence controller for the three-channel RGB PWM datapath. Holds a small programmable table of RGB setpoints. Steps through the table in order, ramping each channel linearly toward the next setpoint, then holding it. Drives the duty inputs of the three PWM channels in place of encoder-driven values. Configured from logic-analyser bits in the wrapper.

---
 rtl/rgb_mixer_pkg.sv | 13 +
 rtl/rgb_tick_gen.sv | 28 ++
 rtl/rgb_fade_sequencer.sv | 98 +++++++++
 tb/tb_rgb_fade_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg: shared state encoding, default sizes and the per-channel step direction.
package rgb_mixer_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, FADE = 2'd1, HOLD = 2'd2} state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ENTRIES = 4;

    function automatic logic signed [1:0] step_dir(input logic [31:0] cur, input logic [31:0] tgt);
        return (cur < tgt) ? 2'sd1 : (cur > tgt) ? -2'sd1 : 2'sd0;
    endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// rgb_tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
module rgb_tick_gen #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    always_comb begin
        wrap  = cnt_q == CW'(TICK_DIV - 1);
        tick  = enable && !clear && wrap;
        cnt_d = (clear || (enable && wrap)) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: steps through a programmable RGB table, ramping each channel
// one count per tick toward the current entry and then holding it.
module rgb_fade_sequencer
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ENTRIES  = DEF_ENTRIES,
    parameter int TICK_DIV = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       cfg_we,
    input  logic [$clog2(ENTRIES)-1:0] cfg_addr,
    input  logic [3*WIDTH-1:0]         cfg_rgb,
    input  logic [7:0]                 hold_steps,
    output logic [WIDTH-1:0]           level0,
    output logic [WIDTH-1:0]           level1,
    output logic [WIDTH-1:0]           level2,
    output logic                       level_valid,
    output logic [$clog2(ENTRIES)-1:0] index,
    output logic                       busy
);

    localparam int AW = $clog2(ENTRIES);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lvl_q [3], lvl_d [3], tgt [3];
    logic [3*WIDTH-1:0] tbl_q [ENTRIES], tbl_d [ENTRIES];
    logic [AW-1:0]      index_q, index_d;
    logic [7:0]         hold_q, hold_d;
    logic               valid_q, valid_d;
    logic               tick, at_tgt, fade_tick, hold_tick;

    rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != IDLE),
        .clear  (state_q == IDLE && run),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE)            ? (run ? FADE : IDLE) :
                  !run                         ? IDLE :
                  (fade_tick && at_tgt)        ? HOLD :
                  (hold_tick && hold_q == 8'd0) ? FADE : state_q;
    end

    always_comb begin
        fade_tick = run && tick && state_q == FADE;
        hold_tick = run && tick && state_q == HOLD;
        at_tgt    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tgt[c] = tbl_q[index_q][(2-c)*WIDTH +: WIDTH];
            at_tgt = at_tgt && lvl_q[c] == tgt[c];
        end
        // the tick that finds all channels on target only moves to HOLD
        for (int c = 0; c < 3; c++)
            lvl_d[c] = (fade_tick && !at_tgt) ? lvl_q[c] + WIDTH'(step_dir(32'(lvl_q[c]), 32'(tgt[c]))) : lvl_q[c];
        valid_d = fade_tick && !at_tgt;
        index_d = (hold_tick && hold_q == 8'd0) ? index_q + 1'b1 : index_q;
        hold_d  = !run                          ? 8'd0 :
                  (fade_tick && at_tgt)         ? hold_steps :
                  (hold_tick && hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;
        tbl_d = tbl_q;
        if (cfg_we) tbl_d[cfg_addr] = cfg_rgb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q   <= '{default: '0};
            tbl_q   <= '{default: '0};
            index_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            tbl_q   <= tbl_d;
            index_q <= index_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign level0      = lvl_q[0];
    assign level1      = lvl_q[1];
    assign level2      = lvl_q[2];
    assign level_valid = valid_q;
    assign index       = index_q;
    assign busy        = state_q != IDLE;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed vector table plus randomized run against a behavioural model.
module tb_rgb_fade_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1, run = 1'b0, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [23:0] cfg_rgb = '0;
    logic [7:0]  hold_steps = 8'd1;
    logic [7:0]  level0, level1, level2;
    logic        level_valid, busy;
    logic [1:0]  index;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(.WIDTH(8), .ENTRIES(4), .TICK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_rgb     (cfg_rgb),
        .hold_steps  (hold_steps),
        .level0      (level0),
        .level1      (level1),
        .level2      (level2),
        .level_valid (level_valid),
        .index       (index),
        .busy        (busy)
    );

    // behavioural model: mode 0 idle, 1 fading, 2 holding; phase counts cycles since (re)start
    int          m_mode = 0, m_phase = 0, m_idx = 0, m_hold = 0;
    int          m_lvl [3] = '{0, 0, 0};
    logic [23:0] m_tbl [4] = '{default: '0};
    bit          m_lv = 1'b0;

    always @(posedge clk) begin : model
        bit tk, eq;
        int t;
        if (reset) begin
            m_mode = 0; m_phase = 0; m_idx = 0; m_hold = 0; m_lv = 1'b0;
            m_lvl = '{0, 0, 0};
            m_tbl = '{default: '0};
        end else begin
            tk   = (m_mode != 0) && (m_phase == 3);
            m_lv = 1'b0;
            if (m_mode == 0) begin
                if (run) begin m_mode = 1; m_phase = 0; end
            end else begin
                m_phase = (m_phase + 1) % 4;
                if (!run) m_mode = 0;
                else if (tk && m_mode == 1) begin
                    eq = 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        t = int'(m_tbl[m_idx][(2-c)*8 +: 8]);
                        if (m_lvl[c] != t) eq = 1'b0;
                    end
                    if (eq) begin m_mode = 2; m_hold = int'(hold_steps); end
                    else begin
                        for (int c = 0; c < 3; c++) begin
                            t = int'(m_tbl[m_idx][(2-c)*8 +: 8]);
                            if (m_lvl[c] < t) m_lvl[c]++;
                            else if (m_lvl[c] > t) m_lvl[c]--;
                        end
                        m_lv = 1'b1;
                    end
                end else if (tk && m_mode == 2) begin
                    if (m_hold == 0) begin m_idx = (m_idx + 1) % 4; m_mode = 1; end
                    else m_hold--;
                end
            end
            if (cfg_we) m_tbl[cfg_addr] = cfg_rgb;
        end
    end

    always @(negedge clk) begin
        logic [28:0] exp_v, got_v;
        if (chk_en) begin
            exp_v = {8'(m_lvl[0]), 8'(m_lvl[1]), 8'(m_lvl[2]), 2'(m_idx), m_mode != 0, m_lv};
            got_v = {level0, level1, level2, index, busy, level_valid};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL model t=%0t got %h exp %h", $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    typedef struct {
        int          n;
        bit          rst, rn, we;
        logic [1:0]  addr;
        logic [23:0] rgb;
        logic [23:0] lvl;
        int          idx;
        bit          bsy;
        int          pulses;
    } vec_t;

    vec_t v [$];
    int   p;

    initial begin
        v.push_back('{  2, 1, 0, 0, 2'd0, 24'h000000, 24'h000000, 0, 0, 0});
        v.push_back('{100, 0, 0, 0, 2'd0, 24'h000000, 24'h000000, 0, 0, 0});
        v.push_back('{  1, 0, 0, 1, 2'd0, 24'h030201, 24'h000000, 0, 0, 0});
        v.push_back('{  1, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 0, 1, 0});
        v.push_back('{ 12, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 0, 1, 3});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 0, 1, 0});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 0, 1, 0});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 1, 1, 0});
        v.push_back('{ 12, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 1, 1, 3});
        v.push_back('{ 12, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 2, 1, 0});
        v.push_back('{ 24, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 0, 1, 0});
        v.push_back('{  8, 0, 1, 0, 2'd0, 24'h000000, 24'h020201, 0, 1, 2});
        v.push_back('{  1, 0, 0, 0, 2'd0, 24'h000000, 24'h020201, 0, 0, 0});
        v.push_back('{ 20, 0, 0, 0, 2'd0, 24'h000000, 24'h020201, 0, 0, 0});
        v.push_back('{  1, 0, 1, 0, 2'd0, 24'h000000, 24'h020201, 0, 1, 0});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 0, 1, 1});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 0, 1, 0});
        v.push_back('{  8, 0, 1, 0, 2'd0, 24'h000000, 24'h030201, 1, 1, 0});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h020100, 1, 1, 1});
        v.push_back('{  4, 0, 1, 1, 2'd1, 24'h050505, 24'h030201, 1, 1, 1});
        v.push_back('{  8, 0, 1, 0, 2'd0, 24'h000000, 24'h050403, 1, 1, 2});
        v.push_back('{  8, 0, 1, 0, 2'd0, 24'h000000, 24'h050505, 1, 1, 2});
        v.push_back('{  4, 0, 1, 0, 2'd0, 24'h000000, 24'h050505, 1, 1, 0});
        v.push_back('{  1, 1, 1, 1, 2'd0, 24'h0A0A0A, 24'h000000, 0, 0, 0});
        v.push_back('{  1, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 0, 1, 0});
        v.push_back('{ 12, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 1, 1, 0});
        v.push_back('{ 12, 0, 1, 0, 2'd0, 24'h000000, 24'h000000, 2, 1, 0});

        @(negedge clk);
        foreach (v[i]) begin
            reset = v[i].rst; run = v[i].rn; cfg_we = v[i].we;
            cfg_addr = v[i].addr; cfg_rgb = v[i].rgb; hold_steps = 8'd1;
            p = 0;
            for (int k = 0; k < v[i].n; k++) begin
                @(posedge clk);
                @(negedge clk);
                cfg_we = 1'b0;
                if (level_valid) p++;
            end
            chk($sformatf("vec%0d_lvl", i), 32'({level0, level1, level2}), 32'(v[i].lvl));
            chk($sformatf("vec%0d_idx", i), 32'(index), 32'(v[i].idx));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(v[i].bsy));
            chk($sformatf("vec%0d_pulses", i), 32'(p), 32'(v[i].pulses));
            chk_en = 1'b1;
        end

        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 299) == 0);
            run        = ($urandom_range(0, 19) != 0);
            cfg_we     = ($urandom_range(0, 15) == 0);
            cfg_addr   = 2'($urandom);
            cfg_rgb    = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            hold_steps = 8'($urandom_range(0, 3));
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
